// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared encodings for the WB-stage exception/CSR commit sequencer
package exc_ctrl_pkg;

    localparam int WB2CSR_LEN = 49;

    localparam logic [1:0] CSR_OP_NONE = 2'b00;
    localparam logic [1:0] CSR_OP_RD   = 2'b01;
    localparam logic [1:0] CSR_OP_WR   = 2'b10;
    localparam logic [1:0] CSR_OP_XCHG = 2'b11;

    localparam logic [5:0] ECODE_INT = 6'h00;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COMMIT   = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    typedef struct packed {
        logic        ertn_flush;
        logic        wb_ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] pc;
    } wb2csr_t;

endpackage

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - turns WB CSR ops into CSR strobes and sequences exception/ertn commit, flush and redirect
module exc_ctrl
    import exc_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [31:0]           wb_pc,
    input  logic [1:0]            wb_csr_op,
    input  logic [13:0]           wb_csr_num,
    input  logic [31:0]           wb_rd_value,
    input  logic [31:0]           wb_rj_value,
    input  logic                  wb_ex,
    input  logic [5:0]            wb_ecode,
    input  logic [8:0]            wb_esubcode,
    input  logic                  wb_ertn,
    output logic                  wb_commit,
    output logic [31:0]           wb_csr_result,
    output logic                  csr_re,
    output logic [13:0]           csr_num,
    input  logic [31:0]           csr_rvalue,
    output logic                  csr_we,
    output logic [31:0]           csr_wmask,
    output logic [31:0]           csr_wvalue,
    output logic [WB2CSR_LEN-1:0] csr_in_bus,
    input  logic [31:0]           ex_entry,
    input  logic [31:0]           ertn_entry,
    input  logic                  has_int,
    output logic                  flush,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [31:0]           redirect_pc
);

    logic [1:0]  state_q, state_d;
    logic        kind_ex_q, kind_ex_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;

    logic    in_idle, in_commit, in_redirect;
    logic    event_hit, normal;
    wb2csr_t bus;

    always_comb begin
        state_d   = state_q;
        kind_ex_d = kind_ex_q;
        ecode_d   = ecode_q;
        esub_d    = esub_q;
        pc_d      = pc_q;
        target_d  = target_q;
        case (state_q)
            S_IDLE: begin
                if (wb_valid) begin
                    // Interrupt outranks the instruction's own exception/ertn; era = wb_pc re-executes it
                    if (has_int) begin
                        kind_ex_d = 1'b1;
                        ecode_d   = ECODE_INT;
                        esub_d    = 9'd0;
                        pc_d      = wb_pc;
                        state_d   = S_COMMIT;
                    end else if (wb_ex) begin
                        kind_ex_d = 1'b1;
                        ecode_d   = wb_ecode;
                        esub_d    = wb_esubcode;
                        pc_d      = wb_pc;
                        state_d   = S_COMMIT;
                    end else if (wb_ertn) begin
                        kind_ex_d = 1'b0;
                        ecode_d   = 6'd0;
                        esub_d    = 9'd0;
                        pc_d      = wb_pc;
                        state_d   = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                target_d = kind_ex_q ? ex_entry : ertn_entry;
                state_d  = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            kind_ex_q <= 1'b0;
            ecode_q   <= 6'd0;
            esub_q    <= 9'd0;
            pc_q      <= 32'd0;
            target_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            kind_ex_q <= kind_ex_d;
            ecode_q   <= ecode_d;
            esub_q    <= esub_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
        end
    end

    // Outputs are gated by reset so a mid-sequence reset never leaks a CSR update or redirect
    assign in_idle     = (state_q == S_IDLE) && !reset;
    assign in_commit   = (state_q == S_COMMIT) && !reset;
    assign in_redirect = (state_q == S_REDIRECT) && !reset;

    assign event_hit = has_int || wb_ex || wb_ertn;
    assign normal    = in_idle && wb_valid && !event_hit;

    assign wb_ready      = (state_q == S_IDLE);
    assign wb_commit     = normal;
    assign wb_csr_result = normal ? csr_rvalue : 32'd0;
    assign csr_num       = wb_csr_num;
    assign csr_re        = normal && (wb_csr_op != CSR_OP_NONE);
    assign csr_we        = normal && ((wb_csr_op == CSR_OP_WR) || (wb_csr_op == CSR_OP_XCHG));
    assign csr_wmask     = !csr_we ? 32'd0 : (wb_csr_op == CSR_OP_WR) ? 32'hFFFF_FFFF : wb_rj_value;
    assign csr_wvalue    = csr_we ? wb_rd_value : 32'd0;

    assign bus.ertn_flush = !kind_ex_q;
    assign bus.wb_ex      = kind_ex_q;
    assign bus.ecode      = ecode_q;
    assign bus.esubcode   = esub_q;
    assign bus.pc         = pc_q;
    assign csr_in_bus     = in_commit ? bus : '0;

    assign flush          = in_commit || in_redirect;
    assign redirect_valid = in_redirect;
    assign redirect_pc    = in_redirect ? target_q : 32'd0;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed and random checks of exc_ctrl against a phase-based reference model
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_pc;
    logic [1:0]  wb_csr_op;
    logic [13:0] wb_csr_num;
    logic [31:0] wb_rd_value, wb_rj_value;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        wb_ertn;
    logic        wb_commit;
    logic [31:0] wb_csr_result;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue, csr_wmask, csr_wvalue;
    logic [48:0] csr_in_bus;
    logic [31:0] ex_entry, ertn_entry;
    logic        has_int, flush, redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: phase 0 = accepting, 1 = the single commit cycle, 2+ = waiting for fetch to take the redirect
    int          m_phase = 0;
    bit          m_ex;
    logic [5:0]  m_ecode;
    logic [8:0]  m_sub;
    logic [31:0] m_pc, m_target;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
        .wb_csr_op(wb_csr_op), .wb_csr_num(wb_csr_num), .wb_rd_value(wb_rd_value),
        .wb_rj_value(wb_rj_value), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_ertn(wb_ertn), .wb_commit(wb_commit), .wb_csr_result(wb_csr_result),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_in_bus(csr_in_bus),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_pc = 0; wb_csr_op = 0; wb_csr_num = 0; wb_rd_value = 0; wb_rj_value = 0;
        wb_ex = 0; wb_ecode = 0; wb_esubcode = 0; wb_ertn = 0; has_int = 0; csr_rvalue = 0;
        ex_entry = 0; ertn_entry = 0; redirect_ready = 0;
    endtask

    task automatic model_check();
        bit normal, we;
        #1;
        if (reset) return;
        chk("csr_num", csr_num, wb_csr_num);
        if (m_phase == 0) begin
            normal = wb_valid && !(has_int || wb_ex || wb_ertn);
            we     = normal && (wb_csr_op == 2'b10 || wb_csr_op == 2'b11);
            chk("idle_ready", wb_ready, 1);
            chk("idle_commit", wb_commit, normal);
            chk("idle_re", csr_re, normal && wb_csr_op != 2'b00);
            chk("idle_we", csr_we, we);
            chk("idle_wmask", csr_wmask, !we ? 0 : (wb_csr_op == 2'b10 ? 32'hFFFF_FFFF : wb_rj_value));
            chk("idle_wvalue", csr_wvalue, we ? wb_rd_value : 0);
            chk("idle_result", wb_csr_result, normal ? csr_rvalue : 0);
            chk("idle_flush", flush, 0);
            chk("idle_rv", redirect_valid, 0);
            chk("idle_rpc", redirect_pc, 0);
            chk("idle_bus", csr_in_bus, 0);
        end else begin
            chk("busy_ready", wb_ready, 0);
            chk("busy_commit", wb_commit, 0);
            chk("busy_re", csr_re, 0);
            chk("busy_we", csr_we, 0);
            chk("busy_flush", flush, 1);
            if (m_phase == 1) begin
                chk("commit_rv", redirect_valid, 0);
                chk("commit_rpc", redirect_pc, 0);
                chk("commit_kind", csr_in_bus[48:47], m_ex ? 2'b01 : 2'b10);
                if (m_ex) chk("commit_bus", csr_in_bus, {2'b01, m_ecode, m_sub, m_pc});
            end else begin
                chk("redir_rv", redirect_valid, 1);
                chk("redir_rpc", redirect_pc, m_target);
                chk("redir_bus", csr_in_bus, 0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) m_phase = 0;
        else if (m_phase == 0) begin
            if (wb_valid && (has_int || wb_ex || wb_ertn)) begin
                m_phase = 1;
                m_ex    = has_int || wb_ex;
                m_ecode = has_int ? 6'h00 : wb_ecode;
                m_sub   = has_int ? 9'h0 : wb_esubcode;
                m_pc    = wb_pc;
            end
        end else if (m_phase == 1) begin
            m_target = m_ex ? ex_entry : ertn_entry;
            m_phase  = 2;
        end else if (redirect_ready) m_phase = 0;
        else m_phase++;
        @(negedge clk);
    endtask

    task automatic step();
        model_check();
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(negedge clk);
        tick(); tick();
        reset = 0;
        model_check();
        chk("rst_ready", wb_ready, 1);
        chk("rst_flush", flush, 0);
        chk("rst_rpc", redirect_pc, 0);
        tick();

        // csrwr SAVE0
        wb_valid = 1; wb_csr_op = 2'b10; wb_csr_num = 14'h30; wb_rd_value = 32'h1234_5678;
        csr_rvalue = 32'hA5A5_A5A5; wb_pc = 32'h1C00_0000;
        model_check();
        chk("csrwr_we", csr_we, 1);
        chk("csrwr_wmask", csr_wmask, 32'hFFFF_FFFF);
        chk("csrwr_result", wb_csr_result, 32'hA5A5_A5A5);
        tick();

        // csrxchg CRMD, back to back
        wb_csr_op = 2'b11; wb_csr_num = 14'h0; wb_rj_value = 32'h7; wb_rd_value = 32'h5; csr_rvalue = 32'h8;
        model_check();
        chk("xchg_wmask", csr_wmask, 32'h7);
        chk("xchg_wvalue", csr_wvalue, 32'h5);
        chk("xchg_result", wb_csr_result, 32'h8);
        chk("xchg_commit", wb_commit, 1);
        tick();

        // synchronous exception with fetch ready
        wb_csr_op = 0; wb_ex = 1; wb_ecode = 6'h0B; wb_esubcode = 9'h3; wb_pc = 32'h1C00_0100;
        ex_entry = 32'h1C00_8000; redirect_ready = 1;
        model_check();
        chk("ex_t0_commit", wb_commit, 0);
        tick();
        wb_valid = 0; wb_ex = 0;
        model_check();
        chk("ex_t1_bus", csr_in_bus, {2'b01, 6'h0B, 9'h3, 32'h1C00_0100});
        tick();
        model_check();
        chk("ex_t2_rpc", redirect_pc, 32'h1C00_8000);
        tick();
        model_check();
        chk("ex_t3_idle", wb_ready, 1);
        tick();

        // interrupt beats a csrwr
        wb_valid = 1; has_int = 1; wb_csr_op = 2'b10; wb_pc = 32'h1C00_0444; wb_ex = 1; wb_ertn = 1;
        model_check();
        chk("int_we", csr_we, 0);
        tick();
        idle_inputs();
        model_check();
        chk("int_bus", csr_in_bus, {2'b01, 6'h00, 9'h0, 32'h1C00_0444});
        tick();
        redirect_ready = 1;
        step();

        // ertn with fetch stalled three cycles
        wb_valid = 1; wb_ertn = 1; ertn_entry = 32'h1C00_0200; redirect_ready = 0;
        step();
        idle_inputs(); ertn_entry = 32'h1C00_0200;
        model_check();
        chk("ertn_flushbit", csr_in_bus[48], 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            redirect_ready = (i == 3);
            model_check();
            chk("ertn_rpc_stable", redirect_pc, 32'h1C00_0200);
            chk("ertn_rv_stable", redirect_valid, 1);
            tick();
        end
        redirect_ready = 0;
        model_check();
        chk("ertn_back_idle", wb_ready, 1);

        // reset while in REDIRECT
        wb_valid = 1; wb_ex = 1; wb_pc = 32'h1C00_0600; ex_entry = 32'h1C00_9000;
        step();
        idle_inputs();
        step(); step();
        chk("rst_mid_rv", redirect_valid, 1);
        reset = 1;
        tick();
        reset = 0;
        model_check();
        chk("rst_mid_rv0", redirect_valid, 0);
        chk("rst_mid_bus0", csr_in_bus, 0);
        tick();
        model_check();
        chk("rst_mid_nobus", csr_in_bus, 0);
        tick();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 49) == 0);
            wb_valid       = ($urandom_range(0, 3) != 0);
            wb_pc          = $urandom;
            wb_csr_op      = 2'($urandom);
            wb_csr_num     = 14'($urandom);
            wb_rd_value    = $urandom;
            wb_rj_value    = $urandom;
            wb_ex          = ($urandom_range(0, 9) == 0);
            wb_ecode       = 6'($urandom);
            wb_esubcode    = 9'($urandom);
            wb_ertn        = ($urandom_range(0, 9) == 0);
            has_int        = ($urandom_range(0, 9) == 0);
            csr_rvalue     = $urandom;
            ex_entry       = $urandom;
            ertn_entry     = $urandom;
            redirect_ready = $urandom_range(0, 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
